// File: rtl/event_order_checker.sv
// Opens a window of WIN cycles on trig and checks that each event line toggles once.
// Each line must toggle within TOL cycles of its own offset. The verdict and masks are held until the next window opens.
module event_order_checker #(
  parameter int unsigned WIN   = 16,
  parameter int unsigned OFS_A = 2,
  parameter int unsigned OFS_B = 2,
  parameter int unsigned OFS_C = 2,
  parameter int unsigned OFS_D = 4,
  parameter int unsigned OFS_E = 6,
  parameter int unsigned OFS_F = 2,
  parameter int unsigned TOL   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [5:0] sig_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_mask,
  output logic [5:0] seen_mask,
  output logic       ovl
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WATCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] WIN_C = WIN[7:0];
  localparam logic [8:0] TOL_C = TOL[8:0];

  // Absolute deviation of the toggle cycle from its offset, on 9-bit unsigned values.
  function automatic logic off_window(input logic [7:0] cnt, input logic [8:0] ofs,
                                      input logic [8:0] tol);
    logic [8:0] cnt9;
    logic [8:0] dev;
    cnt9 = {1'b0, cnt};
    if (cnt9 >= ofs) begin
      dev = cnt9 - ofs;
    end else begin
      dev = ofs - cnt9;
    end
    return (dev > tol);
  endfunction

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] prev_q, prev_d;
  logic [5:0] seen_q, seen_d;
  logic [5:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       ovl_q, ovl_d;

  logic [7:0] cnt_cur_s;
  logic [5:0] tog_s;
  logic [5:0] dev_err_s;
  logic [5:0] seen_upd_s;
  logic [5:0] err_upd_s;
  logic [5:0] err_close_s;

  // cnt_q holds the count of completed watch cycles, so the cycle being evaluated is cnt_q+1.
  assign cnt_cur_s = cnt_q + 8'd1;
  assign tog_s     = sig_in ^ prev_q;

  assign dev_err_s[0] = off_window(cnt_cur_s, OFS_A[8:0], TOL_C);
  assign dev_err_s[1] = off_window(cnt_cur_s, OFS_B[8:0], TOL_C);
  assign dev_err_s[2] = off_window(cnt_cur_s, OFS_C[8:0], TOL_C);
  assign dev_err_s[3] = off_window(cnt_cur_s, OFS_D[8:0], TOL_C);
  assign dev_err_s[4] = off_window(cnt_cur_s, OFS_E[8:0], TOL_C);
  assign dev_err_s[5] = off_window(cnt_cur_s, OFS_F[8:0], TOL_C);

  // A repeat toggle is always an error; a first toggle is an error only when it is off-window.
  assign seen_upd_s  = seen_q | tog_s;
  assign err_upd_s   = err_q | (tog_s & seen_q) | (tog_s & ~seen_q & dev_err_s);
  assign err_close_s = err_upd_s | ~seen_upd_s;

  // Compute next state and all next register values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    seen_d  = seen_q;
    err_d   = err_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    ovl_d   = ovl_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_WATCH;
          cnt_d   = 8'd0;
          prev_d  = sig_in;
          seen_d  = 6'd0;
          err_d   = 6'd0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WATCH: begin
        cnt_d  = cnt_cur_s;
        prev_d = sig_in;
        seen_d = seen_upd_s;
        ovl_d  = ovl_q | trig;
        if (cnt_cur_s == WIN_C) begin
          state_d = ST_DONE;
          err_d   = err_close_s;
          pass_d  = (err_close_s == 6'd0);
          done_d  = 1'b1;
        end else begin
          err_d  = err_upd_s;
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      prev_q  <= 6'd0;
      seen_q  <= 6'd0;
      err_q   <= 6'd0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovl_q   <= ovl_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_mask  = err_q;
  assign seen_mask = seen_q;
  assign ovl       = ovl_q;

endmodule

// File: tb/tb_event_order_checker.sv
// Bench for event_order_checker: directed windows plus random windows checked against a toggle-counting model.
// It uses two instances: one with default parameters, and one with WIN=8, TOL=1, OFS_E=7.
module tb_event_order_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       trig_a, trig_b;
  logic [5:0] sig_a, sig_b;
  logic       busy_a, done_a, pass_a, ovl_a;
  logic [5:0] err_a, seen_a;
  logic       busy_b, done_b, pass_b, ovl_b;
  logic [5:0] err_b, seen_b;

  int errors = 0;
  int checks = 0;

  logic [5:0] wave [0:255];
  logic       sel_b = 1'b0;
  logic       exp_ovl_a = 1'b0;
  int         ofs_a_tab [6] = '{2, 2, 2, 4, 6, 2};
  int         ofs_b_tab [6] = '{2, 2, 2, 4, 7, 2};

  logic       o_busy, o_done, o_pass, o_ovl;
  logic [5:0] o_err, o_seen;
  assign o_busy = sel_b ? busy_b : busy_a;
  assign o_done = sel_b ? done_b : done_a;
  assign o_pass = sel_b ? pass_b : pass_a;
  assign o_ovl  = sel_b ? ovl_b  : ovl_a;
  assign o_err  = sel_b ? err_b  : err_a;
  assign o_seen = sel_b ? seen_b : seen_a;

  event_order_checker dut_a (
    .clk(clk), .rst(rst), .trig(trig_a), .sig_in(sig_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_mask(err_a), .seen_mask(seen_a), .ovl(ovl_a)
  );

  event_order_checker #(.WIN(8), .TOL(1), .OFS_E(7)) dut_b (
    .clk(clk), .rst(rst), .trig(trig_b), .sig_in(sig_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_mask(err_b), .seen_mask(seen_b), .ovl(ovl_b)
  );

  task automatic set_in(input logic t, input logic [5:0] s);
    if (sel_b) begin
      trig_b = t;
      sig_b  = s;
    end else begin
      trig_a = t;
      sig_a  = s;
    end
  endtask

  // Directed wave: a,b,c,f toggle at 2; d at d_at; e at e_at; a again at a_at2 (0 = no toggle).
  task automatic build_wave(input int win, input int e_at, input int d_at, input int a_at2);
    wave[0] = 6'd0;
    for (int k = 1; k <= win; k++) begin
      wave[k] = wave[k-1];
      if (k == 2) wave[k] = wave[k] ^ 6'b100111;
      if (k == d_at) wave[k] = wave[k] ^ 6'b001000;
      if (k == e_at) wave[k] = wave[k] ^ 6'b010000;
      if (k == a_at2) wave[k] = wave[k] ^ 6'b000001;
    end
  endtask

  // Run one window from wave[] and check the verdict against the given expected values.
  task automatic run_window(input int win, input logic [5:0] x_err, input logic [5:0] x_seen,
                            input logic x_pass, input int ovl_at, input logic trig_done,
                            input string name);
    logic busy_bad;
    logic x_ovl;
    busy_bad = 1'b0;
    @(negedge clk);
    set_in(1'b1, wave[0]);
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (o_busy !== 1'b1 || o_done !== 1'b0) busy_bad = 1'b1;
      set_in(k == ovl_at, wave[k]);
    end
    if (ovl_at > 0 && !sel_b) exp_ovl_a = 1'b1;
    x_ovl = sel_b ? 1'b0 : exp_ovl_a;
    checks++; if (busy_bad !== 1'b0) begin errors++; $display("FAIL %s busy_window: busy/done wrong during window", name); end
    @(negedge clk);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL %s done: got %b want 1", name, o_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b want 0", name, o_busy); end
    checks++; if (o_pass !== x_pass) begin errors++; $display("FAIL %s pass: got %b want %b", name, o_pass, x_pass); end
    checks++; if (o_err !== x_err) begin errors++; $display("FAIL %s err_mask: got %b want %b", name, o_err, x_err); end
    checks++; if (o_seen !== x_seen) begin errors++; $display("FAIL %s seen_mask: got %b want %b", name, o_seen, x_seen); end
    checks++; if (o_ovl !== x_ovl) begin errors++; $display("FAIL %s ovl: got %b want %b", name, o_ovl, x_ovl); end
    set_in(trig_done, 6'($urandom));
    @(negedge clk);
    set_in(1'b0, 6'($urandom));
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL %s after_done: done=%b busy=%b want 0 0", name, o_done, o_busy); end
    checks++; if ({o_pass, o_err, o_seen} !== {x_pass, x_err, x_seen}) begin errors++; $display("FAIL %s hold: got %b want %b", name, {o_pass, o_err, o_seen}, {x_pass, x_err, x_seen}); end
    checks++; if (o_ovl !== x_ovl) begin errors++; $display("FAIL %s ovl_hold: got %b want %b", name, o_ovl, x_ovl); end
  endtask

  // Reference: count toggles per line over the window and judge the first one against its offset.
  task automatic model(input int win, output logic [5:0] e, output logic [5:0] s, output logic p);
    int n, first, dev, tol, ofs;
    tol = sel_b ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      first = 0;
      ofs = sel_b ? ofs_b_tab[i] : ofs_a_tab[i];
      for (int k = 1; k <= win; k++) begin
        if (wave[k][i] != wave[k-1][i]) begin
          if (n == 0) first = k;
          n++;
        end
      end
      dev = first - ofs;
      if (dev < 0) dev = -dev;
      s[i] = (n > 0);
      e[i] = (n != 1) || (dev > tol);
    end
    p = (e == 6'd0);
  endtask

  task automatic gen_random(input int win);
    logic [5:0] tg [0:255];
    int mode, k, k2, ofs;
    for (int j = 0; j <= win; j++) tg[j] = 6'd0;
    for (int i = 0; i < 6; i++) begin
      mode = int'($urandom_range(0, 5));
      ofs = sel_b ? ofs_b_tab[i] : ofs_a_tab[i];
      case (mode)
        0: k = 0;
        1, 2, 3: begin
          k = ofs + int'($urandom_range(0, 2)) - 1;
          if (k < 1) k = 1;
          if (k > win) k = win;
          tg[k][i] = ~tg[k][i];
        end
        4: begin
          k = int'($urandom_range(1, win));
          tg[k][i] = ~tg[k][i];
        end
        default: begin
          k = int'($urandom_range(1, win));
          k2 = int'($urandom_range(1, win));
          tg[k][i] = ~tg[k][i];
          tg[k2][i] = ~tg[k2][i];
        end
      endcase
    end
    wave[0] = 6'($urandom);
    for (int j = 1; j <= win; j++) wave[j] = wave[j-1] ^ tg[j];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy_a, done_a, pass_a, ovl_a, err_a, seen_a} !== 16'd0) begin errors++; $display("FAIL reset_a: got %h want 0", {busy_a, done_a, pass_a, ovl_a, err_a, seen_a}); end
    checks++; if ({busy_b, done_b, pass_b, ovl_b, err_b, seen_b} !== 16'd0) begin errors++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, pass_b, ovl_b, err_b, seen_b}); end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    sel_b = 1'b0;
    build_wave(16, 6, 4, 0);
    run_window(16, 6'd0, 6'h3F, 1'b1, 0, 1'b0, "nominal");
  endtask

  task automatic test_late_line;
    build_wave(16, 7, 4, 0);
    run_window(16, 6'b010000, 6'h3F, 1'b0, 0, 1'b0, "late_e");
  endtask

  task automatic test_missing_double;
    build_wave(16, 6, 0, 9);
    run_window(16, 6'b001001, 6'b110111, 1'b0, 0, 1'b0, "missing_double");
  endtask

  task automatic test_overlap;
    int extra_done;
    build_wave(16, 6, 4, 0);
    run_window(16, 6'd0, 6'h3F, 1'b1, 5, 1'b0, "overlap");
    extra_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || busy_a !== 1'b0) extra_done++;
    end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL overlap_single: got %0d extra busy/done cycles want 0", extra_done); end
    checks++; if (ovl_a !== 1'b1) begin errors++; $display("FAIL overlap_sticky: got %b want 1", ovl_a); end
  endtask

  task automatic test_trig_in_done;
    build_wave(16, 6, 4, 0);
    run_window(16, 6'd0, 6'h3F, 1'b1, 0, 1'b1, "trig_in_done");
  endtask

  task automatic test_reset_mid;
    sel_b = 1'b0;
    build_wave(16, 7, 4, 0);
    @(negedge clk);
    set_in(1'b1, wave[0]);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      set_in(1'b0, wave[k]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ovl_a = 1'b0;
    checks++; if ({busy_a, done_a, pass_a, ovl_a, err_a, seen_a} !== 16'd0) begin errors++; $display("FAIL reset_mid: got %h want 0", {busy_a, done_a, pass_a, ovl_a, err_a, seen_a}); end
    build_wave(16, 6, 4, 0);
    run_window(16, 6'd0, 6'h3F, 1'b1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_boundary;
    sel_b = 1'b1;
    build_wave(8, 8, 4, 0);
    run_window(8, 6'd0, 6'h3F, 1'b1, 0, 1'b0, "boundary_e8");
    build_wave(8, 5, 4, 0);
    run_window(8, 6'b010000, 6'h3F, 1'b0, 0, 1'b0, "boundary_e5");
    sel_b = 1'b0;
  endtask

  task automatic test_random;
    logic [5:0] e, s;
    logic p;
    for (int n = 0; n < 30; n++) begin
      sel_b = (n >= 18);
      gen_random(sel_b ? 8 : 16);
      model(sel_b ? 8 : 16, e, s, p);
      run_window(sel_b ? 8 : 16, e, s, p, 0, 1'(n % 2), "random");
    end
    sel_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    trig_a = 1'b0;
    trig_b = 1'b0;
    sig_a = 6'd0;
    sig_b = 6'd0;
    test_reset;
    test_nominal;
    test_late_line;
    test_missing_double;
    test_overlap;
    test_trig_in_done;
    test_reset_mid;
    test_boundary;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
